// File: rtl/fir_pkg.sv
// Shared constants, state type and address-decode helpers for the FIR control block.
package fir_pkg;

  // Register map (byte addresses, word aligned)
  localparam logic [31:0] ADDR_AP_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_LEN      = 32'h0000_0010;
  localparam logic [31:0] ADDR_TAP_BASE = 32'h0000_0020;

  // Bit positions inside ap_ctrl
  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  // Drop the byte offset so every access is treated as a word access.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when the address falls on one of the first num tap words.
  function automatic logic tap_hit(input logic [31:0] addr, input logic [31:0] num);
    logic [31:0] w;
    w = word_addr(addr);
    return (w >= ADDR_TAP_BASE) && (((w - ADDR_TAP_BASE) >> 2) < num);
  endfunction

endpackage

// File: rtl/fir_axil_slave.sv
// AXI-Lite slave handshake engine: accepts one write (address+data together)
// and one read at a time, and reports single-cycle fire strobes to the owner
// of the register file and tap RAM.
//
// Handshake: a transfer completes on a rising edge where valid and ready are
// both high. Masters hold valid (and payload) until then. This slave samples
// valid, then raises ready for exactly one cycle; rvalid holds with stable
// rdata until rready is sampled high, and no new read is accepted meanwhile.
module fir_axil_slave
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   awvalid_i,
  input  logic [pADDR_WIDTH-1:0] awaddr_i,
  input  logic                   wvalid_i,
  input  logic [pDATA_WIDTH-1:0] wdata_i,
  input  logic                   arvalid_i,
  input  logic [pADDR_WIDTH-1:0] araddr_i,
  input  logic                   rready_i,
  output logic                   awready_o,
  output logic                   wready_o,
  output logic                   arready_o,
  output logic                   rvalid_o,
  output logic                   wr_fire_o,
  output logic [pADDR_WIDTH-1:0] wr_addr_o,
  output logic [pDATA_WIDTH-1:0] wr_data_o,
  output logic                   rd_fire_o,
  output logic [pADDR_WIDTH-1:0] rd_addr_o,
  output logic                   rd_first_o
);

  logic                   wr_ack_q, wr_ack_d;
  logic                   ar_ack_q, ar_ack_d;
  logic                   rvalid_q;
  logic                   rd_first_q;
  logic [pADDR_WIDTH-1:0] wr_addr_q;
  logic [pDATA_WIDTH-1:0] wr_data_q;
  logic [pADDR_WIDTH-1:0] rd_addr_q;

  // Accept decisions; a write wins the RAM so a simultaneous read waits a cycle.
  always_comb begin
    wr_ack_d = awvalid_i && wvalid_i && !wr_ack_q;
    ar_ack_d = arvalid_i && !ar_ack_q && !rvalid_q && !wr_ack_d;
  end

  // Handshake pulses, captured payloads and the read-pending flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ack_q   <= 1'b0;
      ar_ack_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rd_first_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      wr_ack_q   <= wr_ack_d;
      ar_ack_q   <= ar_ack_d;
      rd_first_q <= ar_ack_q;
      if (wr_ack_d) begin
        wr_addr_q <= awaddr_i;
        wr_data_q <= wdata_i;
      end
      if (ar_ack_d) begin
        rd_addr_q <= araddr_i;
      end
      if (ar_ack_q) begin
        rvalid_q <= 1'b1;
      end else if (rvalid_q && rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign awready_o  = wr_ack_q;
  assign wready_o   = wr_ack_q;
  assign arready_o  = ar_ack_q;
  assign rvalid_o   = rvalid_q;
  assign wr_fire_o  = wr_ack_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rd_fire_o  = ar_ack_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_first_o = rd_first_q;

endmodule

// File: rtl/fir_ctrl.sv
// FIR control front end: register file, ap_ctrl block protocol FSM and the
// tap RAM arbiter shared between AXI-Lite and the engine.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ap_start,
  output logic [3:0]             tap_we,
  output logic                   tap_en,
  output logic [pADDR_WIDTH-1:0] tap_a,
  output logic [pDATA_WIDTH-1:0] tap_di,
  input  logic [pDATA_WIDTH-1:0] tap_do,
  output logic                   eng_start,
  output logic [31:0]            eng_len,
  input  logic [3:0]             eng_tap_idx,
  output logic [pDATA_WIDTH-1:0] eng_tap_do,
  input  logic                   eng_done,
  output logic                   dbg_state
);

  logic                   wr_fire, rd_fire, rd_first;
  logic [pADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [pDATA_WIDTH-1:0] wr_data;

  fir_axil_slave #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_axil (
    .clk_i      (axis_clk),
    .rst_i      (axis_rst),
    .awvalid_i  (awvalid),
    .awaddr_i   (awaddr),
    .wvalid_i   (wvalid),
    .wdata_i    (wdata),
    .arvalid_i  (arvalid),
    .araddr_i   (araddr),
    .rready_i   (rready),
    .awready_o  (awready),
    .wready_o   (wready),
    .arready_o  (arready),
    .rvalid_o   (rvalid),
    .wr_fire_o  (wr_fire),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .rd_fire_o  (rd_fire),
    .rd_addr_o  (rd_addr),
    .rd_first_o (rd_first)
  );

  ctrl_state_t            state_q;
  logic                   eng_start_q;
  logic [31:0]            eng_len_q;
  logic [31:0]            len_q;
  logic                   done_q;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic                   rd_ram_q;

  logic [31:0]            wr_word, rd_word;
  logic                   wr_is_tap, rd_is_tap;
  logic                   start_req;
  logic                   idle_live;
  logic [pDATA_WIDTH-1:0] rd_val;

  // Address decode and start request (pin or ap_ctrl bit 0 write).
  always_comb begin
    wr_word   = word_addr(32'(wr_addr));
    rd_word   = word_addr(32'(rd_addr));
    wr_is_tap = tap_hit(32'(wr_addr), 32'(Tape_Num));
    rd_is_tap = tap_hit(32'(rd_addr), 32'(Tape_Num));
    start_req = ap_start || (wr_fire && (wr_word == ADDR_AP_CTRL) && wr_data[AP_START]);
    // A done pulse makes idle visible in the same cycle the read samples it.
    idle_live = (state_q == IDLE) || eng_done;
  end

  // Value returned for the read being accepted this cycle.
  always_comb begin
    rd_val = '0;
    if (rd_word == ADDR_AP_CTRL) begin
      rd_val[AP_DONE] = done_q;
      rd_val[AP_IDLE] = idle_live;
    end else if (rd_word == ADDR_LEN) begin
      rd_val = pDATA_WIDTH'(len_q);
    end else if (rd_is_tap && (state_q == RUN)) begin
      rd_val = '1;
    end
  end

  // Tap RAM arbiter: engine owns it in RUN, otherwise AXI write beats AXI read.
  always_comb begin
    tap_we = 4'h0;
    tap_en = 1'b0;
    tap_a  = '0;
    tap_di = wr_data;
    if (state_q == RUN) begin
      tap_en = 1'b1;
      tap_a  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
    end else if (wr_fire && wr_is_tap) begin
      tap_we = 4'hF;
      tap_en = 1'b1;
      tap_a  = pADDR_WIDTH'(wr_word - ADDR_TAP_BASE);
    end else if (rd_fire && rd_is_tap) begin
      tap_en = 1'b1;
      tap_a  = pADDR_WIDTH'(rd_word - ADDR_TAP_BASE);
    end
  end

  // Block-level protocol FSM with data_length, ap_done and engine handoff.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q     <= IDLE;
      eng_start_q <= 1'b0;
      eng_len_q   <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      if (wr_fire && (wr_word == ADDR_LEN) && (state_q == IDLE)) begin
        len_q <= 32'(wr_data);
      end
      // Read-to-clear; any set below in the same cycle takes priority.
      if (rd_fire && (rd_word == ADDR_AP_CTRL)) begin
        done_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_req) begin
            if (len_q != '0) begin
              state_q     <= RUN;
              eng_len_q   <= len_q;
              eng_start_q <= 1'b1;
              done_q      <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (eng_done) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data register; tap reads pick up RAM output in the first rvalid cycle.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rdata_q  <= '0;
      rd_ram_q <= 1'b0;
    end else if (rd_fire) begin
      rdata_q  <= rd_val;
      rd_ram_q <= rd_is_tap && (state_q == IDLE);
    end else if (rd_first && rd_ram_q) begin
      rdata_q  <= tap_do;
      rd_ram_q <= 1'b0;
    end
  end

  assign rdata      = (rd_first && rd_ram_q) ? tap_do : rdata_q;
  assign eng_start  = eng_start_q;
  assign eng_len    = eng_len_q;
  assign eng_tap_do = tap_do;
  assign dbg_state  = state_q;

endmodule
